// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks with FIPS 180-4 padding.
// Optional macro SHA256_PADDER_CNT_EN adds msg_count, a 16-bit count of completed messages.
module sha256_padder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
`ifdef SHA256_PADDER_CNT_EN
  ,
  output logic [15:0]  msg_count
`endif
);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

  state_t            state_q, state_d;
  logic [15:0][31:0] wordBuf_q, wordBuf_d;
  logic [3:0]        widx_q, widx_d;
  logic [63:0]       bitLen_q, bitLen_d;
  logic              first_q, first_d;
  logic              extra_q, extra_d;
  logic              markPending_q, markPending_d;
  logic              ended_q, ended_d;

  logic        acceptWord;
  logic        blkFire;
  logic [2:0]  nEff;
  logic [31:0] markedWord;

  assign in_ready   = rst_n && (state_q == FILL);
  assign blk_valid  = (state_q == EMIT);
  assign blk_first  = blk_valid && first_q;
  assign blk_last   = blk_valid && ended_q && !markPending_q && !extra_q;
  assign acceptWord = in_valid && in_ready;
  assign blkFire    = blk_valid && blk_ready;
  assign nEff       = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;

  // Word 0 of the buffer drives the top 32 bits of the block.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < 16; i++) begin
      blk_data[511-32*i -: 32] = wordBuf_q[i];
    end
  end

  // Final partial word: keep the valid bytes, then the 0x80 marker and zero fill.
  always_comb begin
    case (nEff)
      3'd0:    markedWord = 32'h8000_0000;
      3'd1:    markedWord = {in_data[31:24], 24'h80_0000};
      3'd2:    markedWord = {in_data[31:16], 16'h8000};
      default: markedWord = {in_data[31:8], 8'h80};
    endcase
  end

  always_comb begin
    state_d       = state_q;
    wordBuf_d     = wordBuf_q;
    widx_d        = widx_q;
    bitLen_d      = bitLen_q;
    first_d       = first_q;
    extra_d       = extra_q;
    markPending_d = markPending_q;
    ended_d       = ended_q;

    unique case (state_q)
      FILL: begin
        if (acceptWord) begin
          if (!in_last) begin
            wordBuf_d[widx_q] = in_data;
            bitLen_d          = bitLen_q + 64'd32;
            if (widx_q == 4'd15) state_d = EMIT;
            else                 widx_d  = widx_q + 4'd1;
          end else begin
            ended_d  = 1'b1;
            bitLen_d = bitLen_q + {58'd0, nEff, 3'd0};
            if (nEff == 3'd4) begin
              wordBuf_d[widx_q] = in_data;
              markPending_d     = 1'b1;
            end else begin
              wordBuf_d[widx_q] = markedWord;
              if (widx_q >= 4'd14) extra_d = 1'b1;
            end
            if (widx_q == 4'd15) begin
              state_d = EMIT;
            end else begin
              widx_d  = widx_q + 4'd1;
              state_d = PAD;
            end
          end
        end
      end

      PAD: begin
        // A marker landing in the last two words leaves no room for the length.
        if (markPending_q) begin
          wordBuf_d[widx_q] = 32'h8000_0000;
          markPending_d     = 1'b0;
          if (widx_q >= 4'd14) extra_d = 1'b1;
        end else if (widx_q == 4'd14 && !extra_q) begin
          wordBuf_d[widx_q] = bitLen_q[63:32];
        end else if (widx_q == 4'd15 && !extra_q) begin
          wordBuf_d[widx_q] = bitLen_q[31:0];
        end else begin
          wordBuf_d[widx_q] = 32'h0;
        end
        if (widx_q == 4'd15) state_d = EMIT;
        else                 widx_d  = widx_q + 4'd1;
      end

      EMIT: begin
        if (blkFire) begin
          widx_d  = 4'd0;
          first_d = 1'b0;
          if (blk_last) begin
            bitLen_d = 64'd0;
            first_d  = 1'b1;
            ended_d  = 1'b0;
            state_d  = FILL;
          end else if (ended_q) begin
            extra_d = 1'b0;
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      wordBuf_q     <= '0;
      widx_q        <= 4'd0;
      bitLen_q      <= 64'd0;
      first_q       <= 1'b1;
      extra_q       <= 1'b0;
      markPending_q <= 1'b0;
      ended_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wordBuf_q     <= wordBuf_d;
      widx_q        <= widx_d;
      bitLen_q      <= bitLen_d;
      first_q       <= first_d;
      extra_q       <= extra_d;
      markPending_q <= markPending_d;
      ended_q       <= ended_d;
    end
  end

`ifdef SHA256_PADDER_CNT_EN
  logic [15:0] msgCount_q, msgCount_d;

  assign msgCount_d = (blkFire && blk_last) ? msgCount_q + 16'd1 : msgCount_q;
  assign msg_count  = msgCount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) msgCount_q <= 16'd0;
    else        msgCount_q <= msgCount_d;
  end
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: random messages checked against a byte-level FIPS 180-4 padding model.
// Define SHA256_PADDER_CNT_EN to also check msg_count.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
`ifdef SHA256_PADDER_CNT_EN
  logic [15:0]  msg_count;
`endif

  sha256_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
`ifdef SHA256_PADDER_CNT_EN
    ,
    .msg_count (msg_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int modelMsgCount = 0;
  byte unsigned msgBytes[$];
  logic [511:0] expBlocks[$];

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkValue({tag, ".in_ready"}, 64'(in_ready), 64'd0);
    checkValue({tag, ".blk_valid"}, 64'(blk_valid), 64'd0);
    checkValue({tag, ".blk_first"}, 64'(blk_first), 64'd0);
    checkValue({tag, ".blk_last"}, 64'(blk_last), 64'd0);
    checkOutput({tag, ".blk_data"}, blk_data, 512'd0);
`ifdef SHA256_PADDER_CNT_EN
    checkValue({tag, ".msg_count"}, 64'(msg_count), 64'd0);
`endif
  endtask

  // Reference model: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length, cut into blocks.
  task automatic buildExpected();
    byte unsigned p[$];
    longint unsigned bl;
    logic [511:0] v;
    p = msgBytes;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msgBytes.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    expBlocks.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      v = '0;
      for (int k = 0; k < 64; k++) v[511-8*k -: 8] = p[64*b + k];
      expBlocks.push_back(v);
    end
  endtask

  function automatic logic [31:0] wordAt(input int w);
    logic [31:0] v;
    v = $urandom;
    for (int k = 0; k < 4; k++) begin
      if (4*w + k < msgBytes.size()) v[31-8*k -: 8] = msgBytes[4*w + k];
    end
    return v;
  endfunction

  task automatic applyStimulus(input int len, input bit fixedAbc, input bit overN, input string tag);
    int nWords, lastN, wordIdx, blkIdx, c, acceptIter, firstValidIter, expLat;
    bit timedOut;
    msgBytes.delete();
    if (fixedAbc) begin
      msgBytes.push_back(8'h61);
      msgBytes.push_back(8'h62);
      msgBytes.push_back(8'h63);
    end else begin
      for (int i = 0; i < len; i++) msgBytes.push_back(8'($urandom));
    end
    buildExpected();
    nWords = (msgBytes.size() == 0) ? 1 : (msgBytes.size() + 3) / 4;
    lastN  = msgBytes.size() - 4 * (nWords - 1);
    expLat = (nWords <= 16) ? 17 - nWords : -1;
    wordIdx = 0; blkIdx = 0; c = 0; acceptIter = -1; firstValidIter = -1;
    while (blkIdx < expBlocks.size() && c < 3000) begin
      @(negedge clk);
      if (wordIdx < nWords) begin
        in_valid = 1'b1;
        in_data  = wordAt(wordIdx);
        in_last  = (wordIdx == nWords - 1);
        if (!in_last)                    in_nbytes = 3'($urandom);
        else if (overN && lastN == 4)    in_nbytes = 3'(5 + $urandom_range(0, 2));
        else                             in_nbytes = 3'(lastN);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      blk_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (blk_valid && firstValidIter < 0) firstValidIter = c;
      if (blk_valid && blk_ready) begin
        checkOutput({tag, ".data"}, blk_data, expBlocks[blkIdx]);
        checkValue({tag, ".first"}, 64'(blk_first), 64'(blkIdx == 0));
        checkValue({tag, ".last"}, 64'(blk_last), 64'(blkIdx == expBlocks.size() - 1));
        blkIdx++;
      end
      if (in_valid && in_ready) begin
        if (in_last) acceptIter = c;
        wordIdx++;
      end
      c++;
    end
    timedOut = (c >= 3000);
    checkValue({tag, ".timeout"}, 64'(timedOut), 64'd0);
    if (expLat >= 0 && !timedOut)
      checkValue({tag, ".latency"}, 64'(firstValidIter - acceptIter), 64'(expLat));
    modelMsgCount++;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    #1;
    checkValue({tag, ".idleReady"}, 64'(in_ready), 64'd1);
`ifdef SHA256_PADDER_CNT_EN
    checkValue({tag, ".msg_count"}, 64'(msg_count), 64'(modelMsgCount & 16'hFFFF));
`endif
  endtask

  initial begin
    int lens[] = '{0, 1, 3, 4, 5, 52, 55, 56, 57, 59, 60, 63, 64, 65, 120, 128};
    logic [511:0] abcBlock;
    int waitCnt;
    abcBlock  = {32'h6162_6380, 448'd0, 32'h0000_0018};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    in_nbytes = 3'd0;
    blk_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1 checkReset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1 checkValue("reset.readyAfter", 64'(in_ready), 64'd1);

    $display("[TB] directed abc and boundary lengths");
    applyStimulus(3, 1'b1, 1'b0, "abc");
    for (int i = 0; i < lens.size(); i++) applyStimulus(lens[i], 1'b0, 1'(i % 2), $sformatf("len%0d", lens[i]));

    $display("[TB] random lengths");
    for (int i = 0; i < 8; i++) applyStimulus($urandom_range(0, 200), 1'b0, 1'($urandom), "rand");

    $display("[TB] backpressure");
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h6162_63A5; in_last = 1'b1; in_nbytes = 3'd3;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    waitCnt = 0;
    #1;
    while (!blk_valid && waitCnt < 40) begin
      @(negedge clk);
      #1 waitCnt++;
    end
    checkValue("bp.waitValid", 64'(blk_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp.data", blk_data, abcBlock);
      checkValue("bp.first", 64'(blk_first), 64'd1);
      checkValue("bp.last", 64'(blk_last), 64'd1);
      checkValue("bp.inReady", 64'(in_ready), 64'd0);
      @(negedge clk);
      #1;
    end
    checkValue("bp.stillValid", 64'(blk_valid), 64'd1);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    #1;
    modelMsgCount++;
    checkValue("bp.handshake", 64'(blk_valid), 64'd0);
    checkValue("bp.readyAgain", 64'(in_ready), 64'd1);

    $display("[TB] reset mid-message");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 checkReset("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    modelMsgCount = 0;
    @(negedge clk);
    #1 checkValue("midReset.readyAfter", 64'(in_ready), 64'd1);
    applyStimulus(3, 1'b1, 1'b0, "abcAfterReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
